// File: rtl/rand_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rand_pkg
//  Purpose  : Shared constants, state encoding and the xorshift32 step used
//             by the random-number arbiter and its generator.
//  Revision : 1.0 - initial release
// ============================================================================
package rand_pkg;

  // xorshift32 shift amounts
  localparam int XS_SHL_A = 13;
  localparam int XS_SHR   = 17;
  localparam int XS_SHL_B = 5;

  // xorshift32 has an all-zero fixed point, so a zero seed is replaced
  localparam logic [31:0] ZERO_SEED_SUB = 32'h2545F491;

  // Arbiter response-slot state
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } arb_state_e;

  // One xorshift32 step; all shifts are 32-bit logical and truncated
  function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << XS_SHL_A);
    v = v ^ (v >> XS_SHR);
    v = v ^ (v << XS_SHL_B);
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rand_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rand_arbiter_if
//  Purpose  : Request / response bundle between the requesters and the
//             shared random-number arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface rand_arbiter_if #(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0] REQ_WRITE;
  logic [NUM_REQ-1:0] REQ_READY;
  logic [31:0]        RESP_READ;
  logic [NUM_REQ-1:0] RESP_VALID;
  logic [NUM_REQ-1:0] RESP_ACK;
  logic [15:0]        ISSUED_CNT;

  // Requester side
  modport master (
    output REQ_WRITE,
    output RESP_ACK,
    input  REQ_READY,
    input  RESP_READ,
    input  RESP_VALID,
    input  ISSUED_CNT
  );

  // Arbiter side
  modport slave (
    input  REQ_WRITE,
    input  RESP_ACK,
    output REQ_READY,
    output RESP_READ,
    output RESP_VALID,
    output ISSUED_CNT
  );

endinterface
`default_nettype wire

// File: rtl/rand32_xorshift.sv
`default_nettype none
// ============================================================================
//  Module   : rand32_xorshift
//  Purpose  : 32-bit xorshift generator state; steps once per ADVANCE.
//  Revision : 1.0 - initial release
// ============================================================================
module rand32_xorshift
  import rand_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  input  wire logic        ADVANCE,
  output logic [31:0]      VALUE
);

  localparam logic [31:0] c_SEED_EFF = (SEED == 32'h0) ? ZERO_SEED_SUB : SEED;

  logic [31:0] r_x;

  // Generator state: reload seed on reset, step once per accepted grant
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_x <= c_SEED_EFF;
    end else if (ADVANCE) begin
      r_x <= xorshift32_next(r_x);
    end
  end

  assign VALUE = r_x;

endmodule
`default_nettype wire

// File: rtl/rand_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rand_arbiter
//  Purpose  : Round-robin arbiter sharing one xorshift32 source among
//             NUM_REQ requesters (legal range 2..16). One grant per cycle,
//             each value delivered once and held until acknowledged.
//  Revision : 1.0 - initial release
// ============================================================================
module rand_arbiter
  import rand_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter logic [31:0] SEED    = 32'h1
) (
  input  wire logic        CLK,
  input  wire logic        RESET,
  rand_arbiter_if.slave    bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         r_state;
  arb_state_e         w_state_next;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_g;
  logic [31:0]        r_resp_read;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [15:0]        r_issued_cnt;

  logic [31:0]        w_x;
  logic               w_found;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_ptr_next;
  logic               w_ack_hit;
  logic               w_slot_free;
  logic               w_grant;

  // Shared generator; it only moves when a request is actually accepted
  rand32_xorshift #(
    .SEED (SEED)
  ) u_gen (
    .CLK     (CLK),
    .RESET   (RESET),
    .ADVANCE (w_grant),
    .VALUE   (w_x)
  );

  // Round-robin scan: first set request at or after ptr, wrapping around
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = IDX_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && bus.REQ_WRITE[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  // Only the current grantee's ack frees the slot; stray acks are ignored
  assign w_ack_hit   = (r_state == RESP) && bus.RESP_ACK[r_g];
  assign w_slot_free = (r_state == IDLE) || w_ack_hit;
  assign w_grant     = w_slot_free && w_found && !RESET;
  assign w_ptr_next  = (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : (w_win + IDX_W'(1));

  assign bus.REQ_READY  = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  assign bus.RESP_READ  = r_resp_read;
  assign bus.RESP_VALID = r_resp_valid;
  assign bus.ISSUED_CNT = r_issued_cnt;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a grant always (re)enters RESP; an ack without a grant drains
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (w_grant) begin
          w_state_next = RESP;
        end else if (w_ack_hit) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Response registers, grantee and priority pointer
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_resp_read  <= '0;
      r_resp_valid <= '0;
      r_g          <= '0;
      r_ptr        <= '0;
    end else if (w_grant) begin
      // Generator steps at this same edge, so present the stepped value now
      r_resp_read  <= xorshift32_next(w_x);
      r_resp_valid <= NUM_REQ'(1) << w_win;
      r_g          <= w_win;
      r_ptr        <= w_ptr_next;
    end else if (w_ack_hit) begin
      r_resp_valid <= '0;
    end
  end

  // Delivered-value counter, wraps naturally at 16 bits
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_issued_cnt <= '0;
    end else if (w_ack_hit) begin
      r_issued_cnt <= r_issued_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rand_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rand_arbiter
//  Purpose  : Self-checking bench for rand_arbiter against a behavioural
//             model of the arbitration and generator rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rand_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rand_arbiter_if #(.NUM_REQ(4)) u_if  ();
  rand_arbiter_if #(.NUM_REQ(4)) u_if0 ();

  rand_arbiter #(.NUM_REQ(4), .SEED(32'h1)) u_dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (u_if)
  );

  rand_arbiter #(.NUM_REQ(4), .SEED(32'h0)) u_dut0 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (u_if0)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_x;
  int          m_ptr;
  int          m_g;
  bit          m_busy;
  logic [31:0] m_read;
  logic [3:0]  m_valid;
  logic [15:0] m_cnt;
  int          grant_log[$];

  function automatic logic [31:0] xs(input logic [31:0] v);
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x     = 32'h1;
    m_ptr   = 0;
    m_g     = 0;
    m_busy  = 1'b0;
    m_read  = '0;
    m_valid = '0;
    m_cnt   = '0;
  endtask

  // One clock cycle; entered and left at posedge+1
  task automatic cycle(input logic [3:0] req, input logic [3:0] ack);
    int w;
    bit acked;
    u_if.REQ_WRITE = req;
    u_if.RESP_ACK  = ack;
    #1;
    acked = m_busy && ack[m_g];
    w     = (!m_busy || acked) ? pick(req, m_ptr) : -1;
    check("req_ready", {28'h0, u_if.REQ_READY}, (w >= 0) ? (32'h1 << w) : 32'h0);
    @(posedge clk);
    #1;
    if (acked) m_cnt = m_cnt + 16'd1;
    if (w >= 0) begin
      m_x     = xs(m_x);
      m_read  = m_x;
      m_valid = 4'(1 << w);
      m_g     = w;
      m_ptr   = (w + 1) % 4;
      m_busy  = 1'b1;
      grant_log.push_back(w);
    end else if (acked) begin
      m_busy  = 1'b0;
      m_valid = '0;
    end
    check("resp_valid", {28'h0, u_if.RESP_VALID}, {28'h0, m_valid});
    check("resp_read",  u_if.RESP_READ, m_read);
    check("issued_cnt", {16'h0, u_if.ISSUED_CNT}, {16'h0, m_cnt});
  endtask

  task automatic do_reset();
    u_if.REQ_WRITE = '0;
    u_if.RESP_ACK  = '0;
    rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    grant_log.delete();
    @(posedge clk);
    #1;
  endtask

  int exp_g[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst             = 1'b1;
    u_if.REQ_WRITE  = '0;
    u_if.RESP_ACK   = '0;
    u_if0.REQ_WRITE = '0;
    u_if0.RESP_ACK  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_valid", {28'h0, u_if.RESP_VALID}, 32'h0);
    check("rst_read",  u_if.RESP_READ, 32'h0);
    check("rst_cnt",   {16'h0, u_if.ISSUED_CNT}, 32'h0);
    check("rst_ready", {28'h0, u_if.REQ_READY}, 32'h0);

    // Zero seed: first value is one step from the substitute seed
    u_if0.REQ_WRITE = 4'b0001;
    #1;
    check("zs_ready", {28'h0, u_if0.REQ_READY}, 32'h1);
    @(posedge clk);
    #1;
    u_if0.REQ_WRITE = '0;
    check("zs_read",  u_if0.RESP_READ, xs(32'h2545F491));
    check("zs_valid", {28'h0, u_if0.RESP_VALID}, 32'h1);

    // Single requester, SEED = 1
    cycle(4'b0001, 4'b0000);
    check("single_v1", u_if.RESP_READ, 32'h00042021);
    cycle(4'b0001, 4'b0001);
    check("single_v2", u_if.RESP_READ, 32'h04080601);
    cycle(4'b0000, 4'b0001);
    check("single_cnt", {16'h0, u_if.ISSUED_CNT}, 32'd2);

    // Fairness with all requesters active and matching acks
    do_reset();
    cycle(4'b1111, 4'b0000);
    repeat (5) cycle(4'b1111, m_valid);
    for (int i = 0; i < 5; i++) check("fair_order", grant_log[i], exp_g[i]);

    // Randomised traffic, acks sometimes matching, sometimes stray
    for (int i = 0; i < 300; i++) begin
      logic [3:0] rq;
      logic [3:0] ak;
      rq = 4'($urandom_range(0, 15));
      ak = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) ak = ak | m_valid;
      cycle(rq, ak);
    end

    // Stall: grant to 2, then hold ack low with requester 1 waiting
    cycle(4'b0000, m_valid);
    cycle(4'b0100, 4'b0000);
    check("stall_grant", {28'h0, u_if.RESP_VALID}, 32'h4);
    repeat (5) cycle(4'b0010, 4'b0000);
    // Stray acks on non-grantee bits change nothing
    cycle(4'b0010, 4'b1011);
    check("stray_valid", {28'h0, u_if.RESP_VALID}, 32'h4);
    // Ack releases the slot and requester 1 wins in the same cycle
    cycle(4'b0010, 4'b0100);
    check("stall_next", {28'h0, u_if.RESP_VALID}, 32'h2);

    // Asynchronous reset between edges while a response is pending
    u_if.REQ_WRITE = 4'b1111;
    u_if.RESP_ACK  = 4'b0000;
    rst = 1'b1;
    #2;
    check("arst_valid", {28'h0, u_if.RESP_VALID}, 32'h0);
    check("arst_ready", {28'h0, u_if.REQ_READY}, 32'h0);
    check("arst_cnt",   {16'h0, u_if.ISSUED_CNT}, 32'h0);
    u_if.REQ_WRITE = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(4'b1111, 4'b0000);
    check("arst_first", u_if.RESP_READ, 32'h00042021);
    check("arst_ptr",   {28'h0, u_if.RESP_VALID}, 32'h1);

    // Counter wrap: 65536 acked responses bring the count back to zero
    do_reset();
    for (int i = 0; i < 65537; i++) cycle(4'b1111, m_valid);
    check("wrap_cnt", {16'h0, u_if.ISSUED_CNT}, 32'h0);
    cycle(4'b0000, m_valid);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
